// File: rtl/adc_result_readout_if.sv
// Bus bundle for adc_result_readout: sequencer capture strobe/counts plus the MCU-facing SPI and status lines.
interface adc_result_readout_if #(
    parameter int CW = 24
);
    logic          done;
    logic [CW-1:0] count_up;
    logic [CW-1:0] count_down;
    logic [CW-1:0] count_rundown;
    logic          spi_clk;
    logic          spi_cs;
    logic          spi_dout;
    logic          drdy;
    logic          overrun;

    modport master (
        output done, count_up, count_down, count_rundown, spi_clk, spi_cs,
        input  spi_dout, drdy, overrun
    );

    modport slave (
        input  done, count_up, count_down, count_rundown, spi_clk, spi_cs,
        output spi_dout, drdy, overrun
    );
endinterface

// File: rtl/adc_result_readout.sv
// Double-buffered capture of multi-slope ADC counts, read out MSB first over a read-only SPI port.
// Define ADC_RESULT_CRC_EN to append a serial CRC-8 (poly 0x07) byte to every frame.
module adc_result_readout #(
    parameter int CW   = 24,
    parameter int SYNC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adc_result_readout_if.slave  bus
);
    localparam int RW = 7 + 3*CW;
    localparam int FB = 8 + 3*CW;
`ifdef ADC_RESULT_CRC_EN
    localparam int FW = FB + 8;
`else
    localparam int FW = FB;
`endif
    localparam int BW = $clog2(FW + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    logic [SYNC-1:0] sck_sync_q, cs_sync_q;
    logic            sck_prev_q, cs_prev_q;
    logic            sck_fall, cs_fall, cs_rise;

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] rbuf_q, rbuf_d, pbuf_q, pbuf_d;
    logic          pend_q, pend_d;
    logic          drdy_q, drdy_d;
    logic          ovr_q, ovr_d;
    logic          dout_q, dout_d;
    logic [6:0]    seq_q, seq_d;
    logic [FW-1:0] shreg_q, shreg_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [RW-1:0] capture;

`ifdef ADC_RESULT_CRC_EN
    logic [7:0] crc_q, crc_d, crc_step;
    always_comb begin
        crc_step = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ shreg_q[FW-1]) ? 8'h07 : 8'h00);
    end
`endif

    // Sync resets low so a read cut by reset sees no CS edge and stays idle until CS rises
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync_q <= '0;
            cs_sync_q  <= '0;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b0;
        end else begin
            sck_sync_q <= SYNC'({sck_sync_q, bus.spi_clk});
            cs_sync_q  <= SYNC'({cs_sync_q, bus.spi_cs});
            sck_prev_q <= sck_sync_q[SYNC-1];
            cs_prev_q  <= cs_sync_q[SYNC-1];
        end
    end

    assign sck_fall = sck_prev_q & ~sck_sync_q[SYNC-1];
    assign cs_fall  = cs_prev_q & ~cs_sync_q[SYNC-1];
    assign cs_rise  = ~cs_prev_q & cs_sync_q[SYNC-1];
    assign capture  = {seq_q + 7'd1, bus.count_up, bus.count_down, bus.count_rundown};

    always_comb begin
        state_d  = state_q;
        rbuf_d   = rbuf_q;
        pbuf_d   = pbuf_q;
        pend_d   = pend_q;
        drdy_d   = drdy_q;
        ovr_d    = ovr_q;
        dout_d   = dout_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        seq_d    = bus.done ? seq_q + 7'd1 : seq_q;
`ifdef ADC_RESULT_CRC_EN
        crc_d    = crc_q;
`endif
        case (state_q)
            S_IDLE: begin
                dout_d = 1'b0;
                if (cs_fall) begin
                    state_d = S_LOAD;
                    if (bus.done) begin
                        pbuf_d = capture;
                        pend_d = 1'b1;
                    end
                end else if (bus.done) begin
                    rbuf_d = capture;
                    drdy_d = 1'b1;
                    if (drdy_q) ovr_d = 1'b1;
                end
            end
            S_LOAD, S_SHIFT: begin
                if (cs_rise) begin
                    // A fresh capture on the release clock supersedes the pending one
                    state_d = S_IDLE;
                    dout_d  = 1'b0;
                    if (bus.done) begin
                        rbuf_d = capture;
                        drdy_d = 1'b1;
                        pend_d = 1'b0;
                        if (pend_q) ovr_d = 1'b1;
                    end else if (pend_q) begin
                        rbuf_d = pbuf_q;
                        drdy_d = 1'b1;
                        pend_d = 1'b0;
                    end
                end else begin
                    if (state_q == S_LOAD) begin
                        state_d  = S_SHIFT;
`ifdef ADC_RESULT_CRC_EN
                        shreg_d  = {ovr_q, rbuf_q, 8'h00};
                        crc_d    = 8'h00;
`else
                        shreg_d  = {ovr_q, rbuf_q};
`endif
                        dout_d   = ovr_q;
                        drdy_d   = 1'b0;
                        ovr_d    = 1'b0;
                        bitcnt_d = '0;
                    end else if (sck_fall) begin
                        shreg_d = {shreg_q[FW-2:0], 1'b0};
                        dout_d  = shreg_q[FW-2];
                        if (bitcnt_q != BW'(FW)) bitcnt_d = bitcnt_q + BW'(1);
`ifdef ADC_RESULT_CRC_EN
                        if (bitcnt_q < BW'(FB)) begin
                            crc_d = crc_step;
                            if (bitcnt_q == BW'(FB - 1)) begin
                                shreg_d = {crc_step, {(FW-8){1'b0}}};
                                dout_d  = crc_step[7];
                            end
                        end
`endif
                    end
                    if (bus.done) begin
                        pbuf_d = capture;
                        pend_d = 1'b1;
                        if (pend_q) ovr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                dout_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rbuf_q   <= '0;
            pbuf_q   <= '0;
            pend_q   <= 1'b0;
            drdy_q   <= 1'b0;
            ovr_q    <= 1'b0;
            dout_q   <= 1'b0;
            seq_q    <= '0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
`ifdef ADC_RESULT_CRC_EN
            crc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rbuf_q   <= rbuf_d;
            pbuf_q   <= pbuf_d;
            pend_q   <= pend_d;
            drdy_q   <= drdy_d;
            ovr_q    <= ovr_d;
            dout_q   <= dout_d;
            seq_q    <= seq_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
`ifdef ADC_RESULT_CRC_EN
            crc_q    <= crc_d;
`endif
        end
    end

    assign bus.spi_dout = dout_q;
    assign bus.drdy     = drdy_q;
    assign bus.overrun  = ovr_q;
endmodule

// File: tb/tb_adc_result_readout.sv
// Randomized bench for adc_result_readout against an event-level model of capture, read and overrun rules.
module tb_adc_result_readout;
    localparam int CW = 24;
    localparam int FB = 8 + 3*CW;
`ifdef ADC_RESULT_CRC_EN
    localparam int FW = FB + 8;
`else
    localparam int FW = FB;
`endif
    localparam int HALF = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adc_result_readout_if #(.CW(CW)) bus ();
    adc_result_readout #(.CW(CW), .SYNC(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks   = 0;
    int failures = 0;

    logic [6:0]      m_seq;
    logic [FB-2:0]   m_rbuf, m_pbuf;
    logic            m_pend, m_drdy, m_ovr, m_busy;
    logic [FW-1:0]   m_frame;
    logic [FW-1:0]   rx;

`ifdef ADC_RESULT_CRC_EN
    // CRC as the remainder of polynomial division of data*x^8 by x^8+x^2+x+1
    function automatic logic [7:0] crc8(input logic [FB-1:0] d);
        logic [FB+7:0] r;
        r = {d, 8'h00};
        for (int i = FB + 7; i >= 8; i--)
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        return r[7:0];
    endfunction
`endif

    function automatic logic [FW-1:0] mk_frame(input logic ovr, input logic [FB-2:0] r);
        logic [FB-1:0] f;
        f = {ovr, r};
`ifdef ADC_RESULT_CRC_EN
        return {f, crc8(f)};
`else
        return f;
`endif
    endfunction

    task automatic m_reset();
        m_seq = '0; m_rbuf = '0; m_pbuf = '0;
        m_pend = 1'b0; m_drdy = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
    endtask

    task automatic m_capture(input logic [CW-1:0] u, input logic [CW-1:0] dn, input logic [CW-1:0] rd);
        m_seq = m_seq + 7'd1;
        if (!m_busy) begin
            if (m_drdy) m_ovr = 1'b1;
            m_rbuf = {m_seq, u, dn, rd};
            m_drdy = 1'b1;
        end else begin
            if (m_pend) m_ovr = 1'b1;
            m_pbuf = {m_seq, u, dn, rd};
            m_pend = 1'b1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_done(input logic [CW-1:0] u, input logic [CW-1:0] dn, input logic [CW-1:0] rd);
        bus.done = 1'b1; bus.count_up = u; bus.count_down = dn; bus.count_rundown = rd;
        tick(1);
        bus.done = 1'b0;
        m_capture(u, dn, rd);
    endtask

    task automatic do_done_rand();
        do_done(CW'($urandom), CW'($urandom), CW'($urandom));
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        tick(n);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic spi_begin();
        bus.spi_cs = 1'b0;
        tick(8);
        m_busy  = 1'b1;
        m_frame = mk_frame(m_ovr, m_rbuf);
        m_ovr   = 1'b0;
        m_drdy  = 1'b0;
    endtask

    task automatic spi_bits(input int n);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            rx = {rx[FW-2:0], bus.spi_dout};
            bus.spi_clk = 1'b1;
            tick(HALF);
            bus.spi_clk = 1'b0;
            tick(HALF);
        end
    endtask

    task automatic spi_end();
        bus.spi_cs = 1'b1;
        tick(8);
        m_busy = 1'b0;
        if (m_pend) begin
            m_rbuf = m_pbuf;
            m_pend = 1'b0;
            m_drdy = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        m_reset();
        checks++; if (bus.spi_dout !== 1'b0) begin failures++; $display("FAIL reset_dout got=%b exp=0", bus.spi_dout); end
        checks++; if (bus.drdy !== 1'b0) begin failures++; $display("FAIL reset_drdy got=%b exp=0", bus.drdy); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
        spi_begin(); spi_bits(FW); spi_end();
        checks++; if (rx !== m_frame) begin failures++; $display("FAIL reset_frame got=%h exp=%h", rx, m_frame); end
    endtask

    task automatic test_basic();
        logic [FB-1:0] exp_c;
        exp_c = 80'h01_000123_0000FF_00ABCD;
        do_reset(2);
        do_done(24'h000123, 24'h0000FF, 24'h00ABCD);
        checks++; if (bus.drdy !== 1'b1) begin failures++; $display("FAIL basic_drdy_latency got=%b exp=1", bus.drdy); end
        spi_begin();
        checks++; if (bus.drdy !== 1'b0) begin failures++; $display("FAIL basic_drdy_load got=%b exp=0", bus.drdy); end
        spi_bits(FW);
        checks++; if (rx !== m_frame) begin failures++; $display("FAIL basic_frame got=%h exp=%h", rx, m_frame); end
        checks++; if (rx[FW-1 -: FB] !== exp_c) begin failures++; $display("FAIL basic_const got=%h exp=%h", rx[FW-1 -: FB], exp_c); end
        spi_bits(4);
        checks++; if (rx[3:0] !== 4'h0) begin failures++; $display("FAIL basic_tail got=%h exp=0", rx[3:0]); end
        spi_end();
        checks++; if (bus.drdy !== 1'b0) begin failures++; $display("FAIL basic_drdy_after got=%b exp=0", bus.drdy); end
    endtask

    task automatic test_done_during_read();
        logic [FW-1:0] first, exp1, full;
        logic [3*CW-1:0] exp_cnt;
        exp_cnt = {24'd5, 24'd6, 24'd7};
        do_reset(2);
        do_done_rand();
        spi_begin();
        exp1 = m_frame;
        spi_bits(30);
        first = rx;
        do_done(24'd5, 24'd6, 24'd7);
        checks++; if (bus.drdy !== 1'b0) begin failures++; $display("FAIL ddr_drdy_mid got=%b exp=0", bus.drdy); end
        spi_bits(FW - 30);
        full = (first << (FW - 30)) | rx;
        checks++; if (full !== exp1) begin failures++; $display("FAIL ddr_first_frame got=%h exp=%h", full, exp1); end
        spi_end();
        checks++; if (bus.drdy !== 1'b1) begin failures++; $display("FAIL ddr_drdy_release got=%b exp=1", bus.drdy); end
        spi_begin(); spi_bits(FW); spi_end();
        checks++; if (rx !== m_frame) begin failures++; $display("FAIL ddr_second_frame got=%h exp=%h", rx, m_frame); end
        checks++; if (rx[FW-1 -: 8] !== 8'h02) begin failures++; $display("FAIL ddr_header got=%h exp=02", rx[FW-1 -: 8]); end
        checks++; if (rx[FW-9 -: 3*CW] !== exp_cnt) begin failures++; $display("FAIL ddr_counts got=%h exp=%h", rx[FW-9 -: 3*CW], exp_cnt); end
    endtask

    task automatic test_double_overrun();
        logic [CW-1:0] u2, d2, r2;
        u2 = CW'($urandom); d2 = CW'($urandom); r2 = CW'($urandom);
        do_reset(2);
        do_done_rand();
        spi_begin();
        spi_bits(20);
        do_done_rand();
        spi_bits(20);
        do_done(u2, d2, r2);
        spi_bits(FW - 40);
        spi_end();
        checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", bus.overrun); end
        checks++; if (bus.drdy !== 1'b1) begin failures++; $display("FAIL ovr_drdy got=%b exp=1", bus.drdy); end
        spi_begin();
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear_load got=%b exp=0", bus.overrun); end
        spi_bits(FW); spi_end();
        checks++; if (rx !== m_frame) begin failures++; $display("FAIL ovr_frame got=%h exp=%h", rx, m_frame); end
        checks++; if (rx[FW-1 -: 8] !== 8'h83) begin failures++; $display("FAIL ovr_header got=%h exp=83", rx[FW-1 -: 8]); end
        checks++; if (rx[FW-9 -: 3*CW] !== {u2, d2, r2}) begin failures++; $display("FAIL ovr_counts got=%h exp=%h", rx[FW-9 -: 3*CW], {u2, d2, r2}); end
        spi_begin(); spi_bits(FW); spi_end();
        checks++; if (rx[FW-1] !== 1'b0 || rx !== m_frame) begin failures++; $display("FAIL ovr_third got=%h exp=%h", rx, m_frame); end
    endtask

    task automatic test_seq_wrap();
        do_reset(2);
        for (int i = 0; i < 128; i++) do_done_rand();
        spi_begin(); spi_bits(FW); spi_end();
        checks++; if (rx[FW-1 -: 8] !== 8'h80) begin failures++; $display("FAIL wrap_header got=%h exp=80", rx[FW-1 -: 8]); end
        checks++; if (rx !== m_frame) begin failures++; $display("FAIL wrap_frame got=%h exp=%h", rx, m_frame); end
    endtask

    task automatic test_reset_midread();
        do_reset(2);
        do_done_rand();
        spi_begin();
        spi_bits(40);
        do_reset(1);
        spi_bits(FW - 40);
        checks++; if (rx !== '0) begin failures++; $display("FAIL rmid_tail got=%h exp=0", rx); end
        checks++; if (bus.drdy !== 1'b0) begin failures++; $display("FAIL rmid_drdy got=%b exp=0", bus.drdy); end
        spi_end();
        do_done_rand();
        spi_begin(); spi_bits(FW); spi_end();
        checks++; if (rx[FW-2 -: 7] !== 7'd1) begin failures++; $display("FAIL rmid_seq got=%0d exp=1", rx[FW-2 -: 7]); end
        checks++; if (rx !== m_frame) begin failures++; $display("FAIL rmid_frame got=%h exp=%h", rx, m_frame); end
    endtask

    task automatic test_random();
        logic [FW-1:0] acc, exp;
        int n;
        do_reset(2);
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_done_rand();
            end else begin
                n = $urandom_range(1, FW);
                spi_begin();
                exp = m_frame;
                acc = '0;
                for (int b = 0; b < n; b++) begin
                    if ($urandom_range(0, 15) == 0) do_done_rand();
                    spi_bits(1);
                    acc = {acc[FW-2:0], rx[0]};
                end
                spi_end();
                checks++; if (acc !== (exp >> (FW - n))) begin failures++; $display("FAIL rand_read it=%0d n=%0d got=%h exp=%h", it, n, acc, exp >> (FW - n)); end
            end
            checks++; if (bus.drdy !== m_drdy) begin failures++; $display("FAIL rand_drdy it=%0d got=%b exp=%b", it, bus.drdy, m_drdy); end
            checks++; if (bus.overrun !== m_ovr) begin failures++; $display("FAIL rand_overrun it=%0d got=%b exp=%b", it, bus.overrun, m_ovr); end
        end
    endtask

`ifdef ADC_RESULT_CRC_EN
    task automatic test_crc();
        logic [FB-1:0] body;
        do_reset(2);
        do_done('0, '0, '0);
        spi_begin(); spi_bits(FW); spi_end();
        body = rx[FW-1:8];
        checks++; if (body !== {8'h01, {(3*CW){1'b0}}}) begin failures++; $display("FAIL crc_body got=%h", body); end
        checks++; if (rx[7:0] !== crc8(body)) begin failures++; $display("FAIL crc_byte got=%h exp=%h", rx[7:0], crc8(body)); end
    endtask
`endif

    initial begin
        bus.done = 1'b0; bus.count_up = '0; bus.count_down = '0; bus.count_rundown = '0;
        bus.spi_clk = 1'b0; bus.spi_cs = 1'b1;
        m_reset();
        test_reset();
        test_basic();
        test_done_during_read();
        test_double_overrun();
        test_seq_wrap();
        test_reset_midread();
        test_random();
`ifdef ADC_RESULT_CRC_EN
        test_crc();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_result_readout.md
Name: adc_result_readout

Overview:
- Downstream consumer of the multi-slope ADC sequencer.
- On each conversion-done strobe it captures the run-up, run-down and rundown counts into a result buffer.
- It raises a data-ready line to the MCU and serialises the result over a read-only SPI port (cs high = idle).
- It double-buffers, so a conversion that completes mid-read is neither lost nor torn.

Parameters:
- CW, 24, width of each captured count (count_up, count_down, count_rundown).
- SYNC, 2, synchroniser depth on spi_clk/spi_cs; the edge detector adds one further flop.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- done  in  1  one-cycle strobe from the ADC sequencer: counts valid this cycle
- count_up  in  CW  up-phase count
- count_down  in  CW  down-phase count
- count_rundown  in  CW  rundown clock count
- spi_clk  in  1  async SPI clock from MCU, idle low
- spi_cs  in  1  async chip select, high = deasserted
- spi_dout  out  1  serial data, MSB first
- drdy  out  1  data ready / interrupt, high while an unread result sits in the read buffer
- overrun  out  1  sticky: a result was dropped since the last frame load

Behaviour:
Frame layout:
- Frame = 8 + 3*CW bits (80 at default).
- Header byte = {overrun_flag, seq[6:0]}, then count_up, then count_down, then count_rundown, each MSB first.
- seq is a 7-bit capture counter. It increments on every done and wraps 127->0.

Reset (rst_n low at a clk edge):
- rbuf, pbuf, shreg, seq, bit counter, overrun all cleared to 0.
- pend_valid, drdy, spi_dout cleared to 0.
- State forced to IDLE, whatever the SPI activity. A read in progress yields zeros until cs rises.

Synchronisers:
- spi_clk and spi_cs pass through SYNC flops plus one edge flop.
- SPI falling edge = sync history 2'b10. CS assert = 1->0; CS release = 0->1.
- spi_clk frequency must be <= clk/8.

Read state machine:
- IDLE: cs high. spi_dout = 0. On CS assert -> LOAD.
- LOAD (one cycle): shreg <= {overrun, seq_of_rbuf, rbuf}. spi_dout <= shreg MSB. drdy <= 0. overrun <= 0 (its value is now in the frame). bitcnt <= 0. -> SHIFT.
- SHIFT:
  - Each SPI falling edge: shift left with zero fill, spi_dout <= next bit, bitcnt++.
  - After the frame length, spi_dout holds 0.
  - On CS release -> IDLE, from any bit count; a short read is legal and does not re-raise drdy.

Capture:
- done while IDLE: rbuf <= counts, drdy <= 1, latency 1 clk.
- done while LOAD/SHIFT: pbuf <= counts, pend_valid <= 1. If pend_valid was already 1, the older pending result is discarded and overrun <= 1.
- On CS release with pend_valid: rbuf <= pbuf, pend_valid <= 0, drdy <= 1 on the same clk as the return to IDLE.

Simultaneous events:
- done on the same clk as CS release with pend_valid: new counts go to rbuf, pbuf is dropped, overrun <= 1, drdy <= 1.
- done on the same clk as CS assert: done goes to pbuf; LOAD uses the old rbuf.
- done while drdy already 1 in IDLE: rbuf is overwritten, overrun <= 1.

Optional Feature:
ADC_RESULT_CRC_EN
- Defined: the frame is extended by 8 bits with CRC-8 (poly 0x07, init 0x00, no reflection, no xorout) over all preceding frame bits.
- The CRC is computed serially as bits shift and emitted MSB first immediately after the last count bit. Frame = 88 bits at default.
- Short reads simply truncate.
- Undefined: no CRC logic; the frame is 8 + 3*CW bits.

Test Plan:
- Reset, then done with up=0x000123, down=0x0000FF, rundown=0x00ABCD -> drdy=1 one clk later. An 80-clock SPI read returns 0x01_000123_0000FF_00ABCD. drdy drops at LOAD.
- done during a read (up=5, down=6, rundown=7) -> first frame unchanged, drdy=1 on cs release. Next frame = 0x02_000005_000006_000007, overrun bit 0.
- Two dones during one read, then a second read -> second frame header 0x83 (overrun set, seq=3) with the second set of counts. A third read has the overrun bit clear.
- 128 captures with no reads -> seq wraps; the frame after the 128th capture has header 0x80|0x00 (overrun set, seq 0).
- rst_n low for one clk at bit 40 of a read -> spi_dout=0 for the rest of the read, drdy=0, next done gives seq=1.
- With ADC_RESULT_CRC_EN, counts all 0 and seq=1 -> 88-bit frame whose CRC byte equals a software CRC-8/0x07 over the first 80 bits.
